control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 215 +++++++++++++++++++++
 tb/tb_control_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Instruction-sequencing FSM for the K-and-S core: decodes the IR into datapath strobes,
// resolves conditional branches from the flag register and counts retired instructions.
package k_and_s_pkg;
    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNZERO = 5'd10,
        I_BNEG   = 5'd11,
        I_BNNEG  = 5'd12,
        I_BOV    = 5'd13,
        I_BNOV   = 5'd14,
        I_HALT   = 5'd15
    } decoded_instruction_type;
endpackage

module control_unit
    import k_and_s_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt,
    output logic [CNT_W-1:0]        instr_count
);

    localparam logic [3:0] S_INIT      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_EXEC_ALU  = 4'd3;
    localparam logic [3:0] S_EXEC_MOVE = 4'd4;
    localparam logic [3:0] S_LOAD_1    = 4'd5;
    localparam logic [3:0] S_LOAD_2    = 4'd6;
    localparam logic [3:0] S_STORE_1   = 4'd7;
    localparam logic [3:0] S_EXEC_BR   = 4'd8;
    localparam logic [3:0] S_HALTED    = 4'd9;

    localparam logic [2:0] BR_ALWAYS = 3'd0;
    localparam logic [2:0] BR_ZERO   = 3'd1;
    localparam logic [2:0] BR_NZERO  = 3'd2;
    localparam logic [2:0] BR_NEG    = 3'd3;
    localparam logic [2:0] BR_NNEG   = 3'd4;
    localparam logic [2:0] BR_OV     = 3'd5;
    localparam logic [2:0] BR_NOV    = 3'd6;

    logic [3:0]       state_reg, state_next;
    logic [1:0]       op_reg, op_next;
    logic [2:0]       br_kind_reg, br_kind_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             retire;
    logic             taken;

    // Signed overflow is carried by the flag register but no branch tests it.
    logic unused_signed_overflow;
    assign unused_signed_overflow = signed_overflow;

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S_INIT:   state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (decoded_instruction)
                    I_ADD, I_SUB, I_AND, I_OR: state_next = S_EXEC_ALU;
                    I_MOVE:                    state_next = S_EXEC_MOVE;
                    I_LOAD:                    state_next = S_LOAD_1;
                    I_STORE:                   state_next = S_STORE_1;
                    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
                    I_BNNEG, I_BOV, I_BNOV:    state_next = S_EXEC_BR;
                    I_HALT:                    state_next = S_HALTED;
                    default:                   state_next = S_FETCH;
                endcase
            end
            S_EXEC_ALU, S_EXEC_MOVE, S_LOAD_2,
            S_STORE_1, S_EXEC_BR:              state_next = S_FETCH;
            S_LOAD_1:                          state_next = S_LOAD_2;
            S_HALTED:                          state_next = S_HALTED;
            default:                           state_next = S_INIT;
        endcase
    end

    // ALU op and branch condition are latched at DECODE so the exec-state outputs stay Moore.
    always_comb begin
        op_next      = op_reg;
        br_kind_next = br_kind_reg;
        if (state_reg == S_DECODE) begin
            case (decoded_instruction)
                I_ADD:    op_next = 2'b00;
                I_AND:    op_next = 2'b01;
                I_OR:     op_next = 2'b10;
                I_SUB:    op_next = 2'b11;
                I_MOVE:   op_next = 2'b10;
                default:  op_next = 2'b00;
            endcase
            case (decoded_instruction)
                I_BZERO:  br_kind_next = BR_ZERO;
                I_BNZERO: br_kind_next = BR_NZERO;
                I_BNEG:   br_kind_next = BR_NEG;
                I_BNNEG:  br_kind_next = BR_NNEG;
                I_BOV:    br_kind_next = BR_OV;
                I_BNOV:   br_kind_next = BR_NOV;
                default:  br_kind_next = BR_ALWAYS;
            endcase
        end
    end

    always_comb begin
        taken = 1'b0;
        case (br_kind_reg)
            BR_ALWAYS: taken = 1'b1;
            BR_ZERO:   taken = zero_op;
            BR_NZERO:  taken = ~zero_op;
            BR_NEG:    taken = neg_op;
            BR_NNEG:   taken = ~neg_op;
            BR_OV:     taken = unsigned_overflow;
            BR_NOV:    taken = ~unsigned_overflow;
            default:   taken = 1'b0;
        endcase
    end

    // An instruction retires in its last cycle; NOP/unknown finish in DECODE, HALT never retires.
    always_comb begin
        retire = 1'b0;
        case (state_reg)
            S_DECODE:  retire = (state_next == S_FETCH);
            S_EXEC_ALU, S_EXEC_MOVE, S_LOAD_2,
            S_STORE_1, S_EXEC_BR: retire = 1'b1;
            default:   retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_INIT;
            op_reg      <= 2'b00;
            br_kind_reg <= BR_ALWAYS;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            br_kind_reg <= br_kind_next;
            if (retire) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    always_comb begin
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = 2'b00;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halt             = 1'b0;
        case (state_reg)
            S_FETCH:  ir_enable = 1'b1;
            S_DECODE: pc_enable = 1'b1;
            S_EXEC_ALU: begin
                c_sel            = 1'b1;
                operation        = op_reg;
                write_reg_enable = 1'b1;
                flags_reg_enable = 1'b1;
            end
            S_EXEC_MOVE: begin
                c_sel            = 1'b1;
                operation        = op_reg;
                write_reg_enable = 1'b1;
            end
            S_LOAD_1: addr_sel = 1'b1;
            S_LOAD_2: begin
                addr_sel         = 1'b1;
                write_reg_enable = 1'b1;
            end
            S_STORE_1: begin
                addr_sel         = 1'b1;
                ram_write_enable = 1'b1;
            end
            S_EXEC_BR: begin
                branch    = taken;
                pc_enable = taken;
            end
            S_HALTED: halt = 1'b1;
            default: ;
        endcase
    end

    assign instr_count = cnt_reg;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-instruction expected cycle sequences are queued
// and compared against the DUT every cycle, with literal spot checks on the counter.
module tb_control_unit;
    import k_and_s_pkg::*;

    typedef struct packed {
        logic        branch;
        logic        pc_en;
        logic        ir_en;
        logic        addr_sel;
        logic        c_sel;
        logic [1:0]  op;
        logic        wre;
        logic        fre;
        logic        rwe;
        logic        halt;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    decoded_instruction_type din = I_NOP;
    decoded_instruction_type din4;
    logic zero_op = 1'b0, neg_op = 1'b0, uov = 1'b0, sov = 1'b0;

    logic        branch, pc_enable, ir_enable, addr_sel, c_sel;
    logic [1:0]  operation;
    logic        write_reg_enable, flags_reg_enable, ram_write_enable, halt;
    logic [15:0] instr_count;

    logic        b4, pe4, ie4, as4, cs4, wre4, fre4, rwe4, h4;
    logic [1:0]  op4;
    logic [3:0]  cnt4;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    control_unit #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .decoded_instruction(din),
        .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(uov), .signed_overflow(sov),
        .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable), .addr_sel(addr_sel),
        .c_sel(c_sel), .operation(operation), .write_reg_enable(write_reg_enable),
        .flags_reg_enable(flags_reg_enable), .ram_write_enable(ram_write_enable),
        .halt(halt), .instr_count(instr_count)
    );

    assign din4 = I_NOP;

    control_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .decoded_instruction(din4),
        .zero_op(1'b0), .neg_op(1'b0), .unsigned_overflow(1'b0), .signed_overflow(1'b0),
        .branch(b4), .pc_enable(pe4), .ir_enable(ie4), .addr_sel(as4),
        .c_sel(cs4), .operation(op4), .write_reg_enable(wre4),
        .flags_reg_enable(fre4), .ram_write_enable(rwe4),
        .halt(h4), .instr_count(cnt4)
    );

    // Single compare process: one queued expectation per clock cycle.
    always @(negedge clk) begin
        exp_t e, a;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = '{branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
                  write_reg_enable, flags_reg_enable, ram_write_enable, halt, instr_count};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, a, e);
            end else begin
                $display("cycle t=%0t outputs=%h ok", $time, a);
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end else begin
            $display("check %s = %0d ok", name, act);
        end
    endtask

    function automatic exp_t blank();
        exp_t e;
        e = '0;
        e.cnt = 16'(model_cnt);
        return e;
    endfunction

    function automatic bit taken_of(input decoded_instruction_type ins,
                                    input bit z, input bit n, input bit ov);
        case (ins)
            I_BRANCH: return 1'b1;
            I_BZERO:  return z;
            I_BNZERO: return !z;
            I_BNEG:   return n;
            I_BNNEG:  return !n;
            I_BOV:    return ov;
            I_BNOV:   return !ov;
            default:  return 1'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycles();
        exp_t e;
        model_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(blank());
            step();
        end
        rst_n = 1'b1;
        e = blank();
        exp_q.push_back(e);
        step();
    endtask

    // Queue the expected cycle sequence of one instruction and drive it for its duration.
    task automatic run_instr(input decoded_instruction_type ins, input bit z, input bit n, input bit ov);
        exp_t e;
        din = ins; zero_op = z; neg_op = n; uov = ov; sov = !ov;
        e = blank(); e.ir_en = 1'b1; exp_q.push_back(e); step();
        e = blank(); e.pc_en = 1'b1; exp_q.push_back(e);
        case (ins)
            I_ADD, I_AND, I_OR, I_SUB: begin
                step();
                e = blank(); e.c_sel = 1; e.wre = 1; e.fre = 1;
                e.op = (ins == I_ADD) ? 2'b00 : (ins == I_AND) ? 2'b01 : (ins == I_OR) ? 2'b10 : 2'b11;
                exp_q.push_back(e);
            end
            I_MOVE: begin
                step();
                e = blank(); e.c_sel = 1; e.op = 2'b10; e.wre = 1; exp_q.push_back(e);
            end
            I_LOAD: begin
                step();
                e = blank(); e.addr_sel = 1; exp_q.push_back(e); step();
                e = blank(); e.addr_sel = 1; e.wre = 1; exp_q.push_back(e);
            end
            I_STORE: begin
                step();
                e = blank(); e.addr_sel = 1; e.rwe = 1; exp_q.push_back(e);
            end
            I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
                step();
                e = blank(); e.branch = taken_of(ins, z, n, ov); e.pc_en = e.branch;
                exp_q.push_back(e);
            end
            default: ;
        endcase
        model_cnt = (model_cnt + 1) % 65536;
        step();
    endtask

    // Current cycle's expectation is already queued; pull reset low after its compare.
    task automatic async_reset_mid(input string name);
        #5;
        rst_n = 1'b0;
        #1;
        check({name, "_count"}, instr_count, 16'd0);
        check({name, "_halt"}, {15'd0, halt}, 16'd0);
        check({name, "_strobes"}, {8'd0, write_reg_enable, addr_sel, ram_write_enable,
              ir_enable, pc_enable, branch, operation}, 16'd0);
        @(posedge clk);
        #1;
        reset_cycles();
    endtask

    initial begin
        exp_t e;
        decoded_instruction_type brs[6];
        brs = '{I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV};

        step();
        reset_cycles();

        for (int i = 1; i <= 17; i++) begin
            run_instr(I_NOP, 0, 0, 0);
            if (i == 3)  check("count_after_3_nops", instr_count, 16'd3);
            if (i == 15) check("cnt4_at_15", {12'd0, cnt4}, 16'd15);
            if (i == 16) check("cnt4_wrap_to_0", {12'd0, cnt4}, 16'd0);
        end
        check("cnt4_after_17", {12'd0, cnt4}, 16'd1);
        check("count_after_17_nops", instr_count, 16'd17);

        run_instr(I_ADD, 0, 0, 0);
        run_instr(I_SUB, 0, 0, 0);
        check("count_after_add_sub", instr_count, 16'd19);

        run_instr(I_MOVE, 0, 0, 0);
        run_instr(I_AND, 1, 0, 1);
        run_instr(I_OR, 0, 1, 0);
        run_instr(I_LOAD, 0, 0, 0);
        run_instr(I_STORE, 0, 0, 0);
        run_instr(decoded_instruction_type'(5'd20), 0, 0, 0);
        run_instr(I_BRANCH, 0, 0, 0);
        check("count_after_mix", instr_count, 16'd26);

        foreach (brs[k]) begin
            run_instr(brs[k], 1, 1, 1);
            run_instr(brs[k], 0, 0, 0);
        end
        check("count_after_branches", instr_count, 16'd38);

        // Abort a LOAD in LOAD_1.
        din = I_LOAD;
        e = blank(); e.ir_en = 1; exp_q.push_back(e); step();
        e = blank(); e.pc_en = 1; exp_q.push_back(e); step();
        e = blank(); e.addr_sel = 1; exp_q.push_back(e);
        async_reset_mid("reset_mid_load");

        run_instr(I_NOP, 0, 0, 0);
        run_instr(I_ADD, 0, 0, 0);

        // HALT, then 100 halted cycles with junk on the decode input.
        din = I_HALT;
        e = blank(); e.ir_en = 1; exp_q.push_back(e); step();
        e = blank(); e.pc_en = 1; exp_q.push_back(e); step();
        for (int i = 0; i < 100; i++) begin
            din = decoded_instruction_type'(5'($urandom_range(0, 20)));
            e = blank(); e.halt = 1; exp_q.push_back(e);
            if (i < 99) step();
        end
        check("count_frozen_in_halt", instr_count, 16'd2);
        async_reset_mid("reset_mid_halt");

        run_instr(I_SUB, 0, 0, 0);
        check("count_after_restart", instr_count, 16'd1);

        @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
